// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package pipeline_hazard_ctrl_pkg;

    localparam int DEF_REG_W = 5;
    localparam int DEF_CNT_W = 32;

    // Controller states
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        STALL  = 2'd1,
        HALTED = 2'd2
    } state_t;

    // Hazard lengths (number of bubbles required before ID may advance)
    localparam logic [1:0] STALL_NONE = 2'd0;
    localparam logic [1:0] STALL_ONE  = 2'd1;
    localparam logic [1:0] STALL_TWO  = 2'd2;

    // Register $0 is hard-wired and can never create a hazard
    localparam logic [DEF_REG_W-1:0] REG_ZERO = 5'd0;

    // Per-cycle pipeline-register control bundle
    typedef struct packed {
        logic pc_we;
        logic ifid_we;
        logic idex_we;
        logic exmem_we;
        logic memwb_we;
        logic ifid_flush;
        logic idex_flush;
    } ctl_t;

    // Everything frozen: used for reset, halt, halt-detect and memory wait
    localparam ctl_t CTL_FREEZE   = '{pc_we: 1'b0, ifid_we: 1'b0, idex_we: 1'b0, exmem_we: 1'b0,
                                      memwb_we: 1'b0, ifid_flush: 1'b0, idex_flush: 1'b0};
    // Normal advance of every stage
    localparam ctl_t CTL_ADVANCE  = '{pc_we: 1'b1, ifid_we: 1'b1, idex_we: 1'b1, exmem_we: 1'b1,
                                      memwb_we: 1'b1, ifid_flush: 1'b0, idex_flush: 1'b0};
    // Hold PC and IF/ID, inject a bubble into ID/EX, let the back end drain
    localparam ctl_t CTL_BUBBLE   = '{pc_we: 1'b0, ifid_we: 1'b0, idex_we: 1'b0, exmem_we: 1'b1,
                                      memwb_we: 1'b1, ifid_flush: 1'b0, idex_flush: 1'b1};
    // Taken branch/jump: squash the wrong-path fetch in IF/ID
    localparam ctl_t CTL_REDIRECT = '{pc_we: 1'b1, ifid_we: 1'b0, idex_we: 1'b1, exmem_we: 1'b1,
                                      memwb_we: 1'b1, ifid_flush: 1'b1, idex_flush: 1'b0};

endpackage

// File: rtl/pipeline_hazard_ctrl_perf_counter.sv
// Free-running event counter with enable; wraps at 2^CNT_W.
module perf_counter #(
    parameter int CNT_W = 32
) (
    input  logic             i_CLK,
    input  logic             i_RST,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_count
);

    // Count one per enabled cycle
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST)
            o_count <= '0;
        else if (i_en)
            o_count <= o_count + CNT_W'(1);
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the five-stage MIPS pipeline: load-use and
// branch-operand hazards, data-memory waits, taken branches and halt.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int REG_W = DEF_REG_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             i_CLK,
    input  logic             i_RST,
    input  logic [REG_W-1:0] i_id_rs,
    input  logic [REG_W-1:0] i_id_rt,
    input  logic             i_id_uses_rs,
    input  logic             i_id_uses_rt,
    input  logic             i_id_is_branch,
    input  logic             i_id_br_taken,
    input  logic [REG_W-1:0] i_ex_rd,
    input  logic             i_ex_reg_write,
    input  logic             i_ex_mem_read,
    input  logic [REG_W-1:0] i_mem_rd,
    input  logic             i_mem_mem_read,
    input  logic             i_dmem_busy,
    input  logic             i_wb_halt,
    output logic             o_pc_we,
    output logic             o_ifid_we,
    output logic             o_idex_we,
    output logic             o_exmem_we,
    output logic             o_memwb_we,
    output logic             o_ifid_flush,
    output logic             o_idex_flush,
    output logic [CNT_W-1:0] o_stall_cycles,
    output logic [CNT_W-1:0] o_flush_cycles,
    output logic             o_halted
);

    localparam logic [REG_W-1:0] ZERO_SPEC = REG_W'(REG_ZERO);

    state_t     state_q, state_d;
    logic [1:0] stall_left_q, stall_left_d;
    logic [1:0] haz_len;
    ctl_t       ctl;

    logic ex_src_hit, mem_src_hit;
    logic ex_ld_hit, ex_rw_hit, mem_ld_hit;

    // Source/destination matching and hazard length (first rule wins)
    always_comb begin
        ex_src_hit  = (i_ex_rd != ZERO_SPEC) &&
                      ((i_id_uses_rs && (i_id_rs == i_ex_rd)) ||
                       (i_id_uses_rt && (i_id_rt == i_ex_rd)));
        mem_src_hit = (i_mem_rd != ZERO_SPEC) &&
                      ((i_id_uses_rs && (i_id_rs == i_mem_rd)) ||
                       (i_id_uses_rt && (i_id_rt == i_mem_rd)));
        ex_ld_hit   = i_ex_mem_read  && ex_src_hit;
        ex_rw_hit   = i_ex_reg_write && ex_src_hit;
        mem_ld_hit  = i_mem_mem_read && mem_src_hit;

        haz_len = STALL_NONE;
        if (ex_ld_hit && i_id_is_branch)
            haz_len = STALL_TWO;
        else if (ex_ld_hit)
            haz_len = STALL_ONE;
        else if (ex_rw_hit && i_id_is_branch)
            haz_len = STALL_ONE;
        else if (mem_ld_hit && i_id_is_branch)
            haz_len = STALL_ONE;
    end

    // Next state and control outputs; the ID branch decision is only honoured
    // when ID is actually advancing, since stalled operands are not yet valid
    always_comb begin
        state_d      = state_q;
        stall_left_d = stall_left_q;
        ctl          = CTL_FREEZE;
        if (!i_RST) begin
            case (state_q)
                HALTED: ctl = CTL_FREEZE;
                default: begin
                    if (i_wb_halt) begin
                        ctl     = CTL_FREEZE;
                        state_d = HALTED;
                    end else if (i_dmem_busy) begin
                        ctl = CTL_FREEZE;
                    end else if (state_q == STALL) begin
                        ctl          = CTL_BUBBLE;
                        stall_left_d = stall_left_q - 2'd1;
                        if (stall_left_q <= 2'd1)
                            state_d = RUN;
                    end else if (haz_len != STALL_NONE) begin
                        ctl = CTL_BUBBLE;
                        if (haz_len == STALL_TWO) begin
                            state_d      = STALL;
                            stall_left_d = 2'd1;
                        end
                    end else if (i_id_br_taken) begin
                        ctl = CTL_REDIRECT;
                    end else begin
                        ctl = CTL_ADVANCE;
                    end
                end
            endcase
        end
    end

    // State and remaining-stall registers
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            state_q      <= RUN;
            stall_left_q <= 2'd0;
        end else begin
            state_q      <= state_d;
            stall_left_q <= stall_left_d;
        end
    end

    assign o_pc_we      = ctl.pc_we;
    assign o_ifid_we    = ctl.ifid_we;
    assign o_idex_we    = ctl.idex_we;
    assign o_exmem_we   = ctl.exmem_we;
    assign o_memwb_we   = ctl.memwb_we;
    assign o_ifid_flush = ctl.ifid_flush;
    assign o_idex_flush = ctl.idex_flush;
    assign o_halted     = (state_q == HALTED);

    // PC-frozen cycles include memory waits and the halt-detect cycle
    logic stall_evt;
    assign stall_evt = !i_RST && (state_q != HALTED) && !ctl.pc_we;

    perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .i_CLK  (i_CLK),
        .i_RST  (i_RST),
        .i_en   (stall_evt),
        .o_count(o_stall_cycles)
    );

    perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .i_CLK  (i_CLK),
        .i_RST  (i_RST),
        .i_en   (ctl.ifid_flush),
        .o_count(o_flush_cycles)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench: directed scenarios plus randomized traffic compared
// every cycle against a bubble-count reference model.
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  id_rs = '0, id_rt = '0, ex_rd = '0, mem_rd = '0;
    logic        uses_rs = 0, uses_rt = 0, is_br = 0, br_tk = 0;
    logic        ex_rw = 0, ex_ld = 0, mem_ld = 0, busy = 0, halt = 0;
    logic        pc_we, ifid_we, idex_we, exmem_we, memwb_we, ifid_fl, idex_fl, halted;
    logic [31:0] stall_cnt, flush_cnt;

    // {pc_we, ifid_we, idex_we, exmem_we, memwb_we, ifid_flush, idex_flush}
    localparam logic [6:0] V_FREEZE = 7'b0000000;
    localparam logic [6:0] V_RUN    = 7'b1111100;
    localparam logic [6:0] V_BUB    = 7'b0001101;
    localparam logic [6:0] V_REDIR  = 7'b1011110;

    int n_chk  = 0;
    int n_pass = 0;

    bit          m_halted = 0;
    int          m_extra  = 0;
    logic [31:0] m_stall  = '0;
    logic [31:0] m_flush  = '0;

    pipeline_hazard_ctrl #(.REG_W(5), .CNT_W(32)) dut (
        .i_CLK(clk), .i_RST(rst),
        .i_id_rs(id_rs), .i_id_rt(id_rt), .i_id_uses_rs(uses_rs), .i_id_uses_rt(uses_rt),
        .i_id_is_branch(is_br), .i_id_br_taken(br_tk),
        .i_ex_rd(ex_rd), .i_ex_reg_write(ex_rw), .i_ex_mem_read(ex_ld),
        .i_mem_rd(mem_rd), .i_mem_mem_read(mem_ld),
        .i_dmem_busy(busy), .i_wb_halt(halt),
        .o_pc_we(pc_we), .o_ifid_we(ifid_we), .o_idex_we(idex_we), .o_exmem_we(exmem_we),
        .o_memwb_we(memwb_we), .o_ifid_flush(ifid_fl), .o_idex_flush(idex_fl),
        .o_stall_cycles(stall_cnt), .o_flush_cycles(flush_cnt), .o_halted(halted)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] ctl_vec();
        return {pc_we, ifid_we, idex_we, exmem_we, memwb_we, ifid_fl, idex_fl};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic bit hit(input bit uses, input logic [4:0] s, input logic [4:0] d);
        return uses && (s == d) && (d != 5'd0);
    endfunction

    // Reference model: tracks outstanding bubbles as a plain count
    always @(negedge clk) begin : model
        logic [6:0] e;
        int         n;
        bit         xl, xw, ml;
        if (rst) begin
            chk("m_ctl_rst", ctl_vec(), V_FREEZE);
            chk("m_halted_rst", halted, 0);
            chk("m_stall_rst", stall_cnt, 0);
            chk("m_flush_rst", flush_cnt, 0);
            m_halted = 0; m_extra = 0; m_stall = '0; m_flush = '0;
        end else begin
            xl = ex_ld  && (hit(uses_rs, id_rs, ex_rd)  || hit(uses_rt, id_rt, ex_rd));
            xw = ex_rw  && (hit(uses_rs, id_rs, ex_rd)  || hit(uses_rt, id_rt, ex_rd));
            ml = mem_ld && (hit(uses_rs, id_rs, mem_rd) || hit(uses_rt, id_rt, mem_rd));
            n  = xl ? 1 + int'(is_br) : ((is_br && (xw || ml)) ? 1 : 0);
            chk("m_halted", halted, m_halted);
            chk("m_stall_cnt", stall_cnt, m_stall);
            chk("m_flush_cnt", flush_cnt, m_flush);
            if (m_halted) begin
                e = V_FREEZE;
            end else if (halt) begin
                e = V_FREEZE; m_stall++; m_halted = 1;
            end else if (busy) begin
                e = V_FREEZE; m_stall++;
            end else if (m_extra > 0) begin
                e = V_BUB; m_stall++; m_extra--;
            end else if (n > 0) begin
                e = V_BUB; m_stall++; m_extra = n - 1;
            end else if (br_tk) begin
                e = V_REDIR; m_flush++;
            end else begin
                e = V_RUN;
            end
            chk("m_ctl", ctl_vec(), e);
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic idle();
        id_rs = 0; id_rt = 0; ex_rd = 0; mem_rd = 0;
        uses_rs = 0; uses_rt = 0; is_br = 0; br_tk = 0;
        ex_rw = 0; ex_ld = 0; mem_ld = 0; busy = 0; halt = 0;
    endtask

    task automatic do_reset();
        step(); idle(); rst = 1;
        step(); rst = 0;
    endtask

    initial begin
        // reset state
        step();
        chk("rst_ctl", ctl_vec(), V_FREEZE);
        chk("rst_stall", stall_cnt, 0);
        chk("rst_flush", flush_cnt, 0);
        chk("rst_halted", halted, 0);
        step(); rst = 0;

        // load-use, not a branch: one bubble
        step(); ex_rd = 8; ex_ld = 1; ex_rw = 1; id_rs = 8; uses_rs = 1;
        #1 chk("lu_bubble", ctl_vec(), V_BUB);
        step(); idle();
        #1 chk("lu_resume", ctl_vec(), V_RUN);
        chk("lu_stall_cnt", stall_cnt, 1);

        // load feeding a branch: two bubbles, taken ignored while stalled
        do_reset();
        ex_rd = 8; ex_ld = 1; ex_rw = 1; id_rt = 8; uses_rt = 1; is_br = 1; br_tk = 1;
        #1 chk("ldbr_b1", ctl_vec(), V_BUB);
        step(); ex_rd = 0; ex_ld = 0; ex_rw = 0; mem_rd = 8; mem_ld = 1;
        #1 chk("ldbr_b2", ctl_vec(), V_BUB);
        step(); mem_rd = 0; mem_ld = 0;
        #1 chk("ldbr_redirect", ctl_vec(), V_REDIR);
        chk("ldbr_stall_cnt", stall_cnt, 2);
        chk("ldbr_flush_pre", flush_cnt, 0);
        step(); idle();
        #1 chk("ldbr_flush_cnt", flush_cnt, 1);

        // $0 never hazards
        do_reset();
        ex_rd = 0; ex_ld = 1; ex_rw = 1; id_rs = 0; uses_rs = 1; is_br = 1; mem_rd = 0; mem_ld = 1;
        #1 chk("zero_reg", ctl_vec(), V_RUN);

        // taken branch, no hazard
        step(); idle(); is_br = 1; br_tk = 1; uses_rs = 1; id_rs = 3; ex_rd = 5; ex_rw = 1;
        #1 chk("br_redirect", ctl_vec(), V_REDIR);
        step(); idle();
        #1 chk("br_flush_cnt", flush_cnt, 1);
        chk("br_stall_cnt", stall_cnt, 0);

        // memory wait of 3 cycles inside a 2-cycle stall
        do_reset();
        ex_rd = 8; ex_ld = 1; ex_rw = 1; id_rt = 8; uses_rt = 1; is_br = 1;
        #1 chk("busy_b1", ctl_vec(), V_BUB);
        step(); ex_rd = 0; ex_ld = 0; ex_rw = 0; mem_rd = 8; mem_ld = 1; busy = 1;
        for (int i = 0; i < 3; i++) begin
            #1 chk("busy_freeze", ctl_vec(), V_FREEZE);
            if (i < 2) step();
        end
        step(); busy = 0;
        #1 chk("busy_stall_end", ctl_vec(), V_BUB);
        step(); idle();
        #1 chk("busy_run", ctl_vec(), V_RUN);
        chk("busy_stall_cnt", stall_cnt, 5);

        // halt, then asynchronous reset mid-cycle
        do_reset();
        is_br = 1; br_tk = 1;
        step(); idle(); halt = 1;
        #1 chk("halt_cycle", ctl_vec(), V_FREEZE);
        chk("halt_not_yet", halted, 0);
        step(); halt = 0; br_tk = 1;
        #1 chk("halted", halted, 1);
        chk("halted_ctl", ctl_vec(), V_FREEZE);
        step(); step(); idle();
        #1 chk("halted_stays", halted, 1);
        chk("halt_stall_cnt", stall_cnt, 1);
        chk("halt_flush_cnt", flush_cnt, 1);
        #1 rst = 1;
        #1 chk("arst_ctl", ctl_vec(), V_FREEZE);
        chk("arst_stall", stall_cnt, 0);
        chk("arst_flush", flush_cnt, 0);
        chk("arst_halted", halted, 0);
        step(); rst = 0;
        step();
        #1 chk("arst_run", ctl_vec(), V_RUN);

        // randomized traffic checked by the model
        for (int c = 0; c < 4000; c++) begin
            step();
            id_rs   = 5'($urandom_range(0, 3));
            id_rt   = 5'($urandom_range(0, 3));
            ex_rd   = 5'($urandom_range(0, 3));
            mem_rd  = 5'($urandom_range(0, 3));
            uses_rs = 1'($urandom);
            uses_rt = 1'($urandom);
            is_br   = 1'($urandom);
            br_tk   = is_br && ($urandom_range(0, 1) == 0);
            ex_ld   = ($urandom_range(0, 2) == 0);
            ex_rw   = ex_ld || 1'($urandom);
            mem_ld  = ($urandom_range(0, 2) == 0);
            busy    = ($urandom_range(0, 9) == 0);
            halt    = ($urandom_range(0, 79) == 0);
            rst     = m_halted ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 249) == 0);
        end
        step(); rst = 0; idle();
        step(); step();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
